s1_envio_arduino: RTL

S1_ENVIO_ARDUINO -- requirements
Module: s1_envio_arduino

---
 rtl/s1_arduino_pkg.sv | 33 +++
 rtl/s1_gerador_baud.sv | 28 ++
 rtl/s1_envio_arduino.sv | 106 ++++++++++
 3 files changed

// File: rtl/s1_arduino_pkg.sv
// rtl/s1_arduino_pkg.sv - shared state codes, byte layout and candidate byte builder
package s1_arduino_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        INICIO  = 3'd2,
        DADOS   = 3'd3,
        PARADA  = 3'd4
    } estado_t;

    localparam logic [7:0] BYTE_DESLIGADO = 8'h00;
    localparam int         BIT_SELECAO    = 7;
    localparam int         BIT_ATIVO      = 6;

    // Inactive game always maps to the "all off" byte so the Arduino gets blanked.
    function automatic logic [7:0] montaByte(
        input logic       ativo,
        input logic       selMemoria,
        input logic [3:0] nota,
        input logic [3:0] botoes
    );
        logic [7:0] b;
        b = BYTE_DESLIGADO;
        if (ativo) begin
            b[BIT_SELECAO] = selMemoria;
            b[BIT_ATIVO]   = 1'b1;
            b[3:0]         = selMemoria ? nota : botoes;
        end
        return b;
    endfunction

endpackage

// File: rtl/s1_gerador_baud.sv
// rtl/s1_gerador_baud.sv - bit-period counter with one-cycle end-of-bit tick
module s1_gerador_baud #(
    parameter int DIVISOR = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int             W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [W-1:0]   ULTIMO = W'(DIVISOR - 1);

    logic [W-1:0] contagem;

    assign tick = enable && (contagem == ULTIMO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable) begin
            contagem <= tick ? '0 : contagem + W'(1);
        end
    end

endmodule

// File: rtl/s1_envio_arduino.sv
// rtl/s1_envio_arduino.sv - sends note/button byte to the Arduino over 8N1 UART on change
module s1_envio_arduino
    import s1_arduino_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       activateArduino,
    input  logic       sel_memoria_arduino,
    input  logic [3:0] nota,
    input  logic [3:0] botoes,
    output logic       tx,
    output logic       ocupado,
    output logic       enviado,
    output logic [2:0] db_estado
);
    localparam int DIVISOR = CLK_HZ / BAUD;

    estado_t    estado, proximo;
    logic [7:0] candidato;
    logic [7:0] ultimo;
    logic [7:0] deslocamento;
    logic [2:0] indiceBit;
    logic       fimBit;
    logic       limpaBaud;
    logic       habilitaBaud;

    assign candidato = montaByte(activateArduino, sel_memoria_arduino, nota, botoes);
    assign db_estado = estado;

    s1_gerador_baud #(.DIVISOR(DIVISOR)) gerador (
        .clock  (clock),
        .reset  (reset),
        .clear  (limpaBaud),
        .enable (habilitaBaud),
        .tick   (fimBit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Only the byte captured in CARREGA is sent; later input changes wait for OCIOSO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ultimo       <= BYTE_DESLIGADO;
            deslocamento <= 8'h00;
            indiceBit    <= 3'd0;
        end else if (estado == CARREGA) begin
            ultimo       <= candidato;
            deslocamento <= candidato;
            indiceBit    <= 3'd0;
        end else if (estado == DADOS && fimBit) begin
            deslocamento <= deslocamento >> 1;
            indiceBit    <= indiceBit + 3'd1;
        end
    end

    always_comb begin
        proximo      = estado;
        tx           = 1'b1;
        ocupado      = 1'b0;
        enviado      = 1'b0;
        limpaBaud    = 1'b0;
        habilitaBaud = 1'b0;
        case (estado)
            OCIOSO: begin
                limpaBaud = 1'b1;
                if (candidato != ultimo) proximo = CARREGA;
            end
            CARREGA: begin
                ocupado   = 1'b1;
                limpaBaud = 1'b1;
                proximo   = INICIO;
            end
            INICIO: begin
                ocupado      = 1'b1;
                tx           = 1'b0;
                habilitaBaud = 1'b1;
                if (fimBit) proximo = DADOS;
            end
            DADOS: begin
                ocupado      = 1'b1;
                tx           = deslocamento[0];
                habilitaBaud = 1'b1;
                if (fimBit && indiceBit == 3'd7) proximo = PARADA;
            end
            PARADA: begin
                ocupado      = 1'b1;
                habilitaBaud = 1'b1;
                if (fimBit) begin
                    enviado = 1'b1;
                    proximo = OCIOSO;
                end
            end
            default: proximo = OCIOSO;
        endcase
    end

endmodule
